// File: rtl/an_sec_decode_sched_pkg.sv
// Shared types and defaults for the AN-code (A = 131) SEC decoder scheduler.
package sec_sched_pkg;

  localparam int unsigned AN_A            = 131;
  localparam int unsigned DEF_NREQ        = 4;
  localparam int unsigned DEF_W_BITS      = 61;
  localparam int unsigned DEF_N_BITS      = 53;
  localparam int unsigned DEF_ID_BITS     = 2;
  localparam int unsigned DEF_WDOG_CYCLES = 32;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DISCARD = 2'd1,
    S_WAIT    = 2'd2,
    S_RESP    = 2'd3
  } sched_state_e;

endpackage

// File: rtl/an_sec_decode_sched_if.sv
// Request, decoder-core and response signals of the SEC decode scheduler.
interface an_sec_decode_sched_if
  import sec_sched_pkg::*;
#(
  parameter int unsigned NREQ    = DEF_NREQ,
  parameter int unsigned W_BITS  = DEF_W_BITS,
  parameter int unsigned N_BITS  = DEF_N_BITS,
  parameter int unsigned ID_BITS = DEF_ID_BITS
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*W_BITS-1:0] req_w;
  logic [NREQ-1:0]        req_ready;
  logic [W_BITS-1:0]      core_w;
  logic                   core_found;
  logic [N_BITS-1:0]      core_n;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_BITS-1:0]     rsp_id;
  logic [N_BITS-1:0]      rsp_n;
  logic                   rsp_err;
  logic                   busy;

  modport master (
    output req_valid, req_w, core_found, core_n, rsp_ready,
    input  req_ready, core_w, rsp_valid, rsp_id, rsp_n, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_w, core_found, core_n, rsp_ready,
    output req_ready, core_w, rsp_valid, rsp_id, rsp_n, rsp_err, busy
  );
endinterface

// File: rtl/an_sec_decode_sched_arb.sv
// Round-robin arbiter: first valid requester at or after ptr_i wins.
module sec_rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         grant_o,
  output logic [$clog2(NREQ)-1:0] winner_o
);
  localparam int unsigned IDX_W = $clog2(NREQ);

  always_comb begin
    int unsigned idx;
    logic        found;
    grant_o  = '0;
    winner_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = (32'(ptr_i) + off) % NREQ;
      if (!found && req_i[IDX_W'(idx)]) begin
        found                  = 1'b1;
        grant_o[IDX_W'(idx)]   = 1'b1;
        winner_o               = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/an_sec_decode_sched.sv
// Shares one free-running AN SEC decoder core among NREQ requesters, one codeword in flight.
// Optional watchdog on the core result: define SEC_SCHED_WDOG_EN.
module an_sec_decode_sched
  import sec_sched_pkg::*;
#(
  parameter int unsigned NREQ        = DEF_NREQ,
  parameter int unsigned W_BITS      = DEF_W_BITS,
  parameter int unsigned N_BITS      = DEF_N_BITS,
  parameter int unsigned ID_BITS     = DEF_ID_BITS,
  parameter int unsigned WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input logic                  clk,
  input logic                  rst_n,
  an_sec_decode_sched_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_nreq_chk
    $error("NREQ must be in 2..8");
  end
  if (W_BITS < N_BITS + $clog2(AN_A)) begin : g_w_chk
    $error("W_BITS cannot hold A*N for N_BITS data");
  end
  if ((1 << ID_BITS) < NREQ) begin : g_id_chk
    $error("ID_BITS too narrow for NREQ");
  end
  if (WDOG_CYCLES < 2) begin : g_wdog_chk
    $error("WDOG_CYCLES must be at least 2");
  end

  sched_state_e      state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [W_BITS-1:0] w_q, w_d;
  logic [ID_BITS-1:0] id_q, id_d;
  logic [N_BITS-1:0] n_q, n_d;
  logic [NREQ-1:0]   grant_c, req_ready_c;
  logic [IDX_W-1:0]  winner_c;
  logic [W_BITS-1:0] req_w_a [NREQ];

`ifdef SEC_SCHED_WDOG_EN
  localparam int unsigned CNT_W = $clog2(WDOG_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign req_w_a[g] = bus.req_w[g*W_BITS +: W_BITS];
  end

  sec_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i    (bus.req_valid),
    .ptr_i    (ptr_q),
    .grant_o  (grant_c),
    .winner_o (winner_c)
  );

  // Next state; the first core_found after a load is a stale pass and is skipped.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    w_d         = w_q;
    id_d        = id_q;
    n_d         = n_q;
    req_ready_c = '0;
`ifdef SEC_SCHED_WDOG_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (|bus.req_valid) begin
          req_ready_c = grant_c;
          w_d         = req_w_a[winner_c];
          id_d        = ID_BITS'(winner_c);
          ptr_d       = IDX_W'((32'(winner_c) + 1) % NREQ);
          state_d     = S_DISCARD;
`ifdef SEC_SCHED_WDOG_EN
          cnt_d       = '0;
          err_d       = 1'b0;
`endif
        end
      end
      S_DISCARD: if (bus.core_found) state_d = S_WAIT;
      S_WAIT: begin
        if (bus.core_found) begin
          n_d     = bus.core_n;
          state_d = S_RESP;
        end
      end
      S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef SEC_SCHED_WDOG_EN
    // Give up on a silent core and answer with an error response.
    if (state_q == S_DISCARD || (state_q == S_WAIT && !bus.core_found)) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(WDOG_CYCLES - 1)) begin
        n_d     = '0;
        err_d   = 1'b1;
        state_d = S_RESP;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      w_q     <= '0;
      id_q    <= '0;
      n_q     <= '0;
`ifdef SEC_SCHED_WDOG_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      w_q     <= w_d;
      id_q    <= id_d;
      n_q     <= n_d;
`ifdef SEC_SCHED_WDOG_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.core_w    = w_q;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_n     = n_q;
  assign bus.busy      = (state_q != S_IDLE);
`ifdef SEC_SCHED_WDOG_EN
  assign bus.rsp_err   = err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_an_sec_decode_sched.sv
// Randomized bench for an_sec_decode_sched with a free-running AN-code core stand-in.
module tb_an_sec_decode_sched;
  import sec_sched_pkg::*;

  localparam int unsigned NREQ    = DEF_NREQ;
  localparam int unsigned W_BITS  = DEF_W_BITS;
  localparam int unsigned N_BITS  = DEF_N_BITS;
  localparam int unsigned ID_BITS = DEF_ID_BITS;
  localparam int unsigned WDOG    = DEF_WDOG_CYCLES;
  localparam logic [NREQ-1:0] ONE = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  an_sec_decode_sched_if #(.NREQ(NREQ), .W_BITS(W_BITS), .N_BITS(N_BITS), .ID_BITS(ID_BITS)) bus ();

  an_sec_decode_sched #(
    .NREQ(NREQ), .W_BITS(W_BITS), .N_BITS(N_BITS), .ID_BITS(ID_BITS), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int exp_ptr     = 0;

  logic [W_BITS-1:0] req_w_a [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign bus.req_w[g*W_BITS +: W_BITS] = req_w_a[g];
  end

  // Full SEC decode of an AN codeword: W = 131*N + e, e in {0, +-2^k}.
  function automatic logic [N_BITS-1:0] an_decode(input logic [W_BITS-1:0] w);
    longint unsigned wv, r, p;
    wv = 64'(w);
    r  = wv % 131;
    if (r == 0) return N_BITS'(wv / 131);
    for (int k = 0; k < int'(W_BITS); k++) begin
      p = 64'd1 << k;
      if ((p % 131) == r && wv >= p) return N_BITS'((wv - p) / 131);
      if (((131 - (p % 131)) % 131) == r) return N_BITS'((wv + p) / 131);
    end
    return '0;
  endfunction

  // Core stand-in: samples core_w once per 5-cycle pass, reports it 4 cycles later.
  int                ph       = 0;
  logic [W_BITS-1:0] core_lat = '0;
  bit                core_en  = 1'b1;
  always @(posedge clk) begin
    if (ph == 0) core_lat <= bus.core_w;
    ph <= (ph + 1) % 5;
  end
  assign bus.core_found = core_en && (ph == 4);
  assign bus.core_n     = an_decode(core_lat);

  task automatic make_word(output logic [W_BITS-1:0] w, output logic [N_BITS-1:0] n);
    longint unsigned nv, aw, p;
    int sel;
    nv  = {$urandom, $urandom};
    nv  = nv & 64'h000F_FFFF_FFFF_FFFF;
    aw  = nv * 131;
    sel = $urandom_range(0, 2);
    p   = 64'd1 << $urandom_range(0, 59);
    if (sel == 0)                w = W_BITS'(aw);
    else if (sel == 1 || aw < p) w = W_BITS'(aw + p);
    else                         w = W_BITS'(aw - p);
    n = N_BITS'(nv);
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
    for (int off = 0; off < int'(NREQ); off++)
      if (v[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
    return -1;
  endfunction

  task automatic test_reset;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) req_w_a[i] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.req_ready, bus.core_w, bus.rsp_valid, bus.rsp_id, bus.rsp_n, bus.rsp_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got rdy=%b w=%h v=%b id=%0d n=%h err=%b exp all 0",
               bus.req_ready, bus.core_w, bus.rsp_valid, bus.rsp_id, bus.rsp_n, bus.rsp_err);
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy got %b exp 0", bus.busy);
    end
    rst_n   = 1'b1;
    exp_ptr = 0;
  endtask

  task automatic test_single(input int id, input logic [W_BITS-1:0] w, input logic [N_BITS-1:0] n,
                             input string tag);
    int p, lat;
    @(negedge clk);
    req_w_a[id]   = w;
    bus.req_valid = ONE << id;
    #1;
    p = rr_pick(bus.req_valid, exp_ptr);
    vectors++;
    if (bus.req_ready !== (ONE << p)) begin
      miscompares++; $display("FAIL %s grant got %b exp %b", tag, bus.req_ready, ONE << p);
    end
    exp_ptr = (p + 1) % NREQ;
    @(negedge clk);
    bus.req_valid = '0;
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 14) begin
      vectors++;
      if (bus.req_ready !== '0 || bus.core_w !== w || bus.busy !== 1'b1) begin
        miscompares++;
        $display("FAIL %s hold got rdy=%b w=%h busy=%b exp rdy=0 w=%h busy=1",
                 tag, bus.req_ready, bus.core_w, bus.busy, w);
      end
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (bus.rsp_valid !== 1'b1 || lat < 6 || lat > 11) begin
      miscompares++; $display("FAIL %s latency got %0d valid=%b exp 6..11", tag, lat, bus.rsp_valid);
    end
    vectors++;
    if (bus.rsp_id !== ID_BITS'(id) || bus.rsp_n !== n || bus.rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL %s rsp got id=%0d n=%h err=%b exp id=%0d n=%h err=0",
               tag, bus.rsp_id, bus.rsp_n, bus.rsp_err, id, n);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    vectors++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL %s release got v=%b busy=%b exp 0 0", tag, bus.rsp_valid, bus.busy);
    end
  endtask

  task automatic test_random_singles;
    logic [W_BITS-1:0] w;
    logic [N_BITS-1:0] n;
    for (int i = 0; i < 6; i++) begin
      make_word(w, n);
      test_single($urandom_range(0, NREQ - 1), w, n, "rand_single");
    end
  endtask

  task automatic test_traffic(input bit all_valid, input bit rand_ready, input int n_rsp, input string tag);
    int exp_id_q[$];
    logic [N_BITS-1:0] exp_n_q[$];
    logic [N_BITS-1:0] cur_n [NREQ];
    logic [NREQ-1:0]   vmask, exp_gnt;
    int gp, p, issued, got, cyc;
    for (int i = 0; i < int'(NREQ); i++) make_word(req_w_a[i], cur_n[i]);
    vmask  = all_valid ? '1 : NREQ'($urandom);
    gp     = -1;
    issued = 0;
    got    = 0;
    cyc    = 0;
    while (got < n_rsp && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (gp >= 0) begin
        make_word(req_w_a[gp], cur_n[gp]);
        if (!all_valid) vmask[gp] = 1'($urandom_range(0, 1));
        gp = -1;
      end
      if (!all_valid)
        for (int i = 0; i < int'(NREQ); i++) if (!vmask[i]) vmask[i] = ($urandom_range(0, 3) == 0);
      if (issued >= n_rsp) vmask = '0;
      bus.req_valid = vmask;
      bus.rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      p       = (exp_id_q.size() == 0) ? rr_pick(vmask, exp_ptr) : -1;
      exp_gnt = (p >= 0) ? (ONE << p) : '0;
      vectors++;
      if (bus.req_ready !== exp_gnt) begin
        miscompares++; $display("FAIL %s grant got %b exp %b", tag, bus.req_ready, exp_gnt);
      end
      if (p >= 0) begin
        exp_id_q.push_back(p);
        exp_n_q.push_back(cur_n[p]);
        exp_ptr = (p + 1) % NREQ;
        gp      = p;
        issued++;
      end
      if (bus.rsp_valid === 1'b1) begin
        vectors++;
        if (exp_id_q.size() == 0) begin
          miscompares++; $display("FAIL %s rsp got unexpected id=%0d exp none", tag, bus.rsp_id);
        end else if (bus.rsp_id !== ID_BITS'(exp_id_q[0]) || bus.rsp_n !== exp_n_q[0] || bus.rsp_err !== 1'b0) begin
          miscompares++;
          $display("FAIL %s rsp got id=%0d n=%h err=%b exp id=%0d n=%h err=0",
                   tag, bus.rsp_id, bus.rsp_n, bus.rsp_err, exp_id_q[0], exp_n_q[0]);
        end
        if (bus.rsp_ready && exp_id_q.size() > 0) begin
          void'(exp_id_q.pop_front());
          void'(exp_n_q.pop_front());
          got++;
        end
      end
    end
    @(negedge clk);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    vectors++;
    if (got != n_rsp) begin
      miscompares++; $display("FAIL %s timeout got %0d responses exp %0d", tag, got, n_rsp);
    end
  endtask

  task automatic test_backpressure;
    logic [W_BITS-1:0] w3, w0;
    logic [N_BITS-1:0] n3, n0;
    int p, lat;
    make_word(w3, n3);
    make_word(w0, n0);
    @(negedge clk);
    req_w_a[3]    = w3;
    bus.req_valid = ONE << 3;
    #1;
    p = rr_pick(bus.req_valid, exp_ptr);
    vectors++;
    if (bus.req_ready !== (ONE << p)) begin
      miscompares++; $display("FAIL bp_grant3 got %b exp %b", bus.req_ready, ONE << p);
    end
    exp_ptr = (p + 1) % NREQ;
    @(negedge clk);
    req_w_a[0]    = w0;
    bus.req_valid = ONE;
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 14) begin
      @(negedge clk);
      lat++;
    end
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== ID_BITS'(3) || bus.rsp_n !== n3 || bus.req_ready !== '0) begin
        miscompares++;
        $display("FAIL bp_hold got v=%b id=%0d n=%h rdy=%b exp v=1 id=3 n=%h rdy=0",
                 bus.rsp_valid, bus.rsp_id, bus.rsp_n, bus.req_ready, n3);
      end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1;
    vectors++;
    if (bus.req_ready !== '0) begin
      miscompares++; $display("FAIL bp_accept_cycle got rdy=%b exp 0", bus.req_ready);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    p = rr_pick(bus.req_valid, exp_ptr);
    vectors++;
    if (bus.req_ready !== (ONE << p)) begin
      miscompares++; $display("FAIL bp_next_grant got %b exp %b", bus.req_ready, ONE << p);
    end
    exp_ptr = (p + 1) % NREQ;
    @(negedge clk);
    bus.req_valid = '0;
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 14) begin
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== ID_BITS'(0) || bus.rsp_n !== n0) begin
      miscompares++;
      $display("FAIL bp_second_rsp got v=%b id=%0d n=%h exp v=1 id=0 n=%h", bus.rsp_valid, bus.rsp_id, bus.rsp_n, n0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_midflight;
    logic [W_BITS-1:0] w;
    logic [N_BITS-1:0] n;
    int lat;
    make_word(w, n);
    @(negedge clk);
    req_w_a[1]    = w;
    bus.req_valid = ONE << 1;
    @(negedge clk);
    bus.req_valid = '0;
    for (int i = 0; i < 8; i++) begin
      if (bus.core_found === 1'b1) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.req_ready, bus.core_w, bus.rsp_valid, bus.rsp_id, bus.rsp_n, bus.rsp_err, bus.busy} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs got rdy=%b w=%h v=%b id=%0d n=%h err=%b busy=%b exp all 0",
               bus.req_ready, bus.core_w, bus.rsp_valid, bus.rsp_id, bus.rsp_n, bus.rsp_err, bus.busy);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    exp_ptr = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
        miscompares++; $display("FAIL midreset_dropped got v=%b busy=%b exp 0 0", bus.rsp_valid, bus.busy);
      end
    end
    make_word(w, n);
    req_w_a[0]    = w;
    bus.req_valid = '1;
    #1;
    vectors++;
    if (bus.req_ready !== ONE) begin
      miscompares++; $display("FAIL midreset_ptr got %b exp %b", bus.req_ready, ONE);
    end
    exp_ptr = 1;
    @(negedge clk);
    bus.req_valid = '0;
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 14) begin
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== ID_BITS'(0) || bus.rsp_n !== n) begin
      miscompares++;
      $display("FAIL midreset_rsp got v=%b id=%0d n=%h exp v=1 id=0 n=%h", bus.rsp_valid, bus.rsp_id, bus.rsp_n, n);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

`ifdef SEC_SCHED_WDOG_EN
  task automatic test_wdog;
    logic [W_BITS-1:0] w;
    logic [N_BITS-1:0] n;
    int lat;
    make_word(w, n);
    core_en = 1'b0;
    @(negedge clk);
    req_w_a[2]    = w;
    bus.req_valid = ONE << 2;
    exp_ptr       = rr_pick(bus.req_valid, exp_ptr) + 1;
    @(negedge clk);
    bus.req_valid = '0;
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (bus.rsp_valid !== 1'b1 || lat < int'(WDOG) || lat > int'(WDOG) + 1 ||
        bus.rsp_err !== 1'b1 || bus.rsp_n !== '0 || bus.rsp_id !== ID_BITS'(2)) begin
      miscompares++;
      $display("FAIL wdog got v=%b lat=%0d err=%b n=%h id=%0d exp v=1 lat=%0d err=1 n=0 id=2",
               bus.rsp_valid, lat, bus.rsp_err, bus.rsp_n, bus.rsp_id, WDOG);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    core_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_traffic(1'b1, 1'b0, 9, "back_to_back");
    test_single(0, 61'd655, 53'd5, "req0_clean");
    test_single(2, 61'd663, 53'd5, "req2_plus8");
    test_single(1, 61'd527, 53'd5, "req1_minus128");
    test_random_singles();
    test_backpressure();
    test_traffic(1'b0, 1'b1, 25, "random_mix");
    test_reset_midflight();
`ifdef SEC_SCHED_WDOG_EN
    test_wdog();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
